python_spi_slave: RTL and testbench
===================================

Name: python_spi_slave

Overview:
SPI responder for the PYTHON300 register protocol: the device-side end of the sensor configuration link. It decodes 26-bit frames (9-bit address, 1-bit we, 16-bit data, MSB first) from an SPI initiator and issues single-cycle register write strobes or read requests on a local register bus. It returns read data on MISO. Used as a sensor model in system simulation and as an FPGA-side register port, so host software and initiator RTL run unchanged against an emulated sensor.

Parameters:
SYNC_STAGES, 2, flip-flop stages on spi_ss_n/spi_sck/spi_mosi before edge detection (>=2)

Ports:
clk  input  1  system clock; must be >= 8x SCK frequency
reset  input  1  synchronous, active-high
spi_ss_n  input  1  chip select, active low (async to clk)
spi_sck  input  1  SPI clock, idle low, mode 0 (async)
spi_mosi  input  1  serial data in; valid at SCK rising edge
spi_miso  output  1  serial data out; changes after SCK falling edge
spi_miso_oe  output  1  MISO drive enable; high only while frame is active
m_addr  output  9  register address of current frame
m_we  output  1  1=write, 0=read
m_wdata  output  16  write data
m_valid  output  1  one-cycle strobe: write command (m_we=1) or read request (m_we=0)
s_rdata  input  16  read data from register bank
s_rvalid  input  1  one-cycle read data valid
err_abort  output  1  one-cycle pulse: ss_n deasserted before 26 rising edges
err_rd_late  output  1  one-cycle pulse: read data missed its deadline

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, m_addr=0, m_we=0, m_wdata=0, m_valid=0, err_abort=0, err_rd_late=0; state IDLE; bit count 0; tx shift register 0. Synchroniser stages reset to ss_n=1, sck=0, mosi=0.
- Edge detection: the synchronised SCK is compared with its previous value to produce rise/fall pulses. The synchronised ss_n gives fall/rise pulses. All actions below occur on the cycle the pulse is detected.
- States:
  - IDLE: on ss_n fall -> CMD; count=0; tx=0; spi_miso_oe=1.
  - CMD: each SCK rise shifts synchronised MOSI into a 10-bit command register and increments count. On rise 10: latch m_addr=bits[9:1], m_we=bit[0].
    - If we=0: pulse m_valid in the same cycle, arm the read wait, go to DATA.
    - If we=1: go to DATA.
  - DATA: each SCK rise shifts MOSI into the 16-bit wdata register and increments count. On rise 26: go to DONE; if we=1, load m_wdata and pulse m_valid in the same cycle.
  - DONE: further SCK edges are ignored. On ss_n rise -> IDLE.
- Read path:
  - s_rvalid while the read wait is armed loads tx=s_rdata and disarms the wait. spi_miso=tx[15] at all times.
  - Each SCK fall in DATA with count in 11..25 shifts tx left and fills 0.
  - Deadline: s_rvalid must arrive before SCK fall 11 is detected. If the wait is still armed at that fall: pulse err_rd_late, disarm, transmit zeros for the frame, and ignore any later s_rvalid.
  - s_rvalid while not armed is ignored.
  - During write frames and the command phase, spi_miso=0.
- ss_n rise in any state other than IDLE/DONE: pulse err_abort, no m_valid, discard partial data, spi_miso_oe=0, spi_miso=0, go to IDLE. ss_n rise in DONE: spi_miso_oe=0, no error.
- ss_n fall while in DONE cannot occur without an intervening rise; a new frame always starts from IDLE.
- m_addr/m_we/m_wdata hold their values until the next latch.
- reset mid-frame returns all state to reset values immediately. The frame in progress is lost; the next frame is decoded only after a fresh ss_n fall.
- Timing budget: SCK half-period must be >= SYNC_STAGES+2 clk. The read responder gets (SCK half-period - SYNC_STAGES - 2) clk after m_valid.

Test Plan:
- Write frame addr=0x0A5, we=1, data=0xBEEF at clk/16 SCK -> exactly one m_valid after rise 26, with m_addr=0x0A5, m_we=1, m_wdata=0xBEEF; spi_miso stays 0.
- Read frame addr=0x1FF, we=0; responder returns s_rdata=0xA5C3 2 clk after m_valid -> m_valid with m_we=0 at rise 10; initiator captures 0xA5C3 at falls 11..26; no errors.
- Read with s_rvalid withheld until after fall 11 -> err_rd_late pulse once, initiator receives 0x0000, late s_rvalid ignored.
- ss_n raised after 14 rising edges of a write to 0x003 -> err_abort pulse, no m_valid, m_addr unchanged. The next full write to 0x004/0x1234 decodes correctly.
- 30 SCK pulses in one frame -> single m_valid at rise 26, extra edges ignored; ss_n rise gives no err_abort.
- reset asserted at rise 12 of a read -> all outputs return to reset values. The next read of 0x010 returning 0x0F0F completes normally.

Source files
------------

// File: rtl/python_spi_slave.sv
// python_spi_slave
// Device-side SPI responder for the PYTHON300 register protocol. Decodes
// 26-bit frames (9-bit address, we, 16-bit data, MSB first, SPI mode 0) into
// single-cycle strobes on a local register bus and returns read data on MISO.
//
// Ports:
//   clk, reset           system clock (>= 8x SCK), synchronous active-high reset
//   spi_ss_n/sck/mosi    SPI inputs, asynchronous to clk
//   spi_miso, _oe        serial read data and its drive enable
//   m_addr/m_we/m_wdata  command of the most recently decoded frame
//   m_valid              one-cycle strobe: write command or read request
//   s_rdata, s_rvalid    read data return from the register bank
//   err_abort            frame ended before 26 SCK rising edges
//   err_rd_late          read data arrived after the transmit deadline
//
// state | meaning
// IDLE  | waiting for ss_n to fall
// CMD   | shifting in address + we (rises 1..10)
// DATA  | shifting in data / shifting out read data (rises 11..26)
// DONE  | frame complete, SCK ignored until ss_n rises

module python_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_ss_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [8:0]  m_addr,
    output logic        m_we,
    output logic [15:0] m_wdata,
    output logic        m_valid,
    input  logic [15:0] s_rdata,
    input  logic        s_rvalid,
    output logic        err_abort,
    output logic        err_rd_late
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
    logic ss_d, sck_d;
    logic ss_s, sck_s, mosi_s;
    logic ss_fall, ss_rise, sck_rise, sck_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sck_d     <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_d      <= ss_s;
            sck_d     <= sck_s;
        end
    end

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_fall  = ss_d & ~ss_s;
    assign ss_rise  = ~ss_d & ss_s;
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    state_t      state, state_n;
    logic [4:0]  count, count_n;
    logic [8:0]  cmd_sr, cmd_sr_n;
    logic [14:0] data_sr, data_sr_n;
    logic [15:0] tx, tx_n;
    logic        rd_armed, rd_armed_n;
    logic [8:0]  m_addr_n;
    logic        m_we_n, m_valid_n, oe_n, err_abort_n, err_rd_late_n;
    logic [15:0] m_wdata_n;

    assign spi_miso = tx[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            tx          <= '0;
            rd_armed    <= 1'b0;
            m_addr      <= '0;
            m_we        <= 1'b0;
            m_wdata     <= '0;
            m_valid     <= 1'b0;
            spi_miso_oe <= 1'b0;
            err_abort   <= 1'b0;
            err_rd_late <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            cmd_sr      <= cmd_sr_n;
            data_sr     <= data_sr_n;
            tx          <= tx_n;
            rd_armed    <= rd_armed_n;
            m_addr      <= m_addr_n;
            m_we        <= m_we_n;
            m_wdata     <= m_wdata_n;
            m_valid     <= m_valid_n;
            spi_miso_oe <= oe_n;
            err_abort   <= err_abort_n;
            err_rd_late <= err_rd_late_n;
        end
    end

    always_comb begin
        state_n       = state;
        count_n       = count;
        cmd_sr_n      = cmd_sr;
        data_sr_n     = data_sr;
        tx_n          = tx;
        rd_armed_n    = rd_armed;
        m_addr_n      = m_addr;
        m_we_n        = m_we;
        m_wdata_n     = m_wdata;
        m_valid_n     = 1'b0;
        oe_n          = spi_miso_oe;
        err_abort_n   = 1'b0;
        err_rd_late_n = 1'b0;

        if (s_rvalid && rd_armed) begin
            tx_n       = s_rdata;
            rd_armed_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n    = CMD;
                    count_n    = '0;
                    tx_n       = '0;
                    rd_armed_n = 1'b0;
                    oe_n       = 1'b1;
                end
            end
            CMD, DATA: begin
                if (ss_rise) begin
                    state_n     = IDLE;
                    count_n     = '0;
                    tx_n        = '0;
                    rd_armed_n  = 1'b0;
                    oe_n        = 1'b0;
                    err_abort_n = 1'b1;
                end else if (sck_rise) begin
                    count_n = count + 5'd1;
                    if (state == CMD) begin
                        cmd_sr_n = {cmd_sr[7:0], mosi_s};
                        if (count == 5'd9) begin
                            // cmd_sr already holds the nine address bits; mosi_s is we
                            m_addr_n = cmd_sr;
                            m_we_n   = mosi_s;
                            state_n  = DATA;
                            if (!mosi_s) begin
                                m_valid_n  = 1'b1;
                                rd_armed_n = 1'b1;
                            end
                        end
                    end else begin
                        data_sr_n = {data_sr[13:0], mosi_s};
                        if (count == 5'd25) begin
                            state_n = DONE;
                            if (m_we) begin
                                m_wdata_n = {data_sr, mosi_s};
                                m_valid_n = 1'b1;
                            end
                        end
                    end
                end else if (sck_fall && state == DATA &&
                             count >= 5'd11 && count <= 5'd25) begin
                    if (count == 5'd11 && rd_armed) begin
                        // Deadline missed: a response landing this same cycle
                        // is dropped too, so the frame carries zeros.
                        err_rd_late_n = 1'b1;
                        rd_armed_n    = 1'b0;
                        tx_n          = '0;
                    end else begin
                        tx_n = {tx[14:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                    // last read bit may still sit in tx[15]; park MISO low
                    tx_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_python_spi_slave.sv
// Directed bench for python_spi_slave: acts as SPI initiator (SCK = clk/16)
// and as a register-bank responder returning read data a set delay after
// each read request.

module tb_python_spi_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_ss_n, spi_sck, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [8:0]  m_addr;
    logic        m_we;
    logic [15:0] m_wdata;
    logic        m_valid;
    logic [15:0] s_rdata;
    logic        s_rvalid;
    logic        err_abort, err_rd_late;

    int total = 0;
    int bad   = 0;

    int mv_cnt = 0, abort_cnt = 0, late_cnt = 0;
    logic [8:0]  last_addr;
    logic        last_we;
    logic [15:0] last_wdata;

    int          rsp_delay = 2;
    logic [15:0] rsp_data  = 16'h0000;

    int mv0, ab0, lt0;
    logic [15:0] cap;

    python_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_ss_n(spi_ss_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_valid(m_valid),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .err_abort(err_abort), .err_rd_late(err_rd_late)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid) begin
            mv_cnt     <= mv_cnt + 1;
            last_addr  <= m_addr;
            last_we    <= m_we;
            last_wdata <= m_wdata;
        end
        if (err_abort)   abort_cnt <= abort_cnt + 1;
        if (err_rd_late) late_cnt  <= late_cnt + 1;
    end

    // register-bank responder
    initial begin
        s_rvalid = 1'b0;
        s_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            s_rvalid = 1'b0;
            if (m_valid && !m_we) begin
                repeat (rsp_delay) @(negedge clk);
                s_rdata  = rsp_data;
                s_rvalid = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},   32'(spi_miso),    32'd0);
        check({tag, "_oe"},     32'(spi_miso_oe), 32'd0);
        check({tag, "_addr"},   32'(m_addr),      32'd0);
        check({tag, "_we"},     32'(m_we),        32'd0);
        check({tag, "_wdata"},  32'(m_wdata),     32'd0);
        check({tag, "_valid"},  32'(m_valid),     32'd0);
        check({tag, "_abort"},  32'(err_abort),   32'd0);
        check({tag, "_late"},   32'(err_rd_late), 32'd0);
    endtask

    // Drive one frame of nbits SCK pulses. MISO is captured at the external
    // SCK falls 11..26. reset_at > 0 asserts reset right after that rise and
    // drops the frame.
    task automatic spi_frame(input logic [25:0] frame, input int nbits,
                             input int reset_at, output logic [15:0] cap_o);
        cap_o = '0;
        spi_ss_n = 1'b0;
        repeat (8) @(negedge clk);
        check("oe_active", 32'(spi_miso_oe), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 26) ? frame[25-i] : 1'b0;
            repeat (8) @(negedge clk);
            spi_sck = 1'b1;
            repeat (8) @(negedge clk);
            if (reset_at == i + 1) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check_reset_outputs("midreset");
                spi_sck  = 1'b0;
                spi_ss_n = 1'b1;
                spi_mosi = 1'b0;
                repeat (4) @(negedge clk);
                reset = 1'b0;
                repeat (8) @(negedge clk);
                return;
            end
            if (i >= 10 && i <= 25) cap_o = {cap_o[14:0], spi_miso};
            spi_sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
        check("oe_idle", 32'(spi_miso_oe), 32'd0);
    endtask

    task automatic snap();
        mv0 = mv_cnt;
        ab0 = abort_cnt;
        lt0 = late_cnt;
    endtask

    initial begin
        reset    = 1'b1;
        spi_ss_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // write 0x0A5 <- 0xBEEF
        snap();
        spi_frame({9'h0A5, 1'b1, 16'hBEEF}, 26, 0, cap);
        check("wr_mvalid_cnt", 32'(mv_cnt - mv0), 32'd1);
        check("wr_addr",  32'(last_addr),  32'h0A5);
        check("wr_we",    32'(last_we),    32'd1);
        check("wr_wdata", 32'(last_wdata), 32'hBEEF);
        check("wr_miso",  32'(cap),        32'd0);
        check("wr_abort", 32'(abort_cnt - ab0), 32'd0);

        // read 0x1FF, responder returns 0xA5C3 two clocks after m_valid
        rsp_data = 16'hA5C3;
        rsp_delay = 2;
        snap();
        spi_frame({9'h1FF, 1'b0, 16'h0000}, 26, 0, cap);
        check("rd_mvalid_cnt", 32'(mv_cnt - mv0), 32'd1);
        check("rd_addr",  32'(last_addr), 32'h1FF);
        check("rd_we",    32'(last_we),   32'd0);
        check("rd_data",  32'(cap),       32'hA5C3);
        check("rd_late",  32'(late_cnt - lt0),  32'd0);
        check("rd_abort", 32'(abort_cnt - ab0), 32'd0);
        check("rd_miso_idle", 32'(spi_miso), 32'd0);

        // read 0x055 with response held back past fall 11
        rsp_data  = 16'hFFFF;
        rsp_delay = 40;
        snap();
        spi_frame({9'h055, 1'b0, 16'h0000}, 26, 0, cap);
        check("late_pulse", 32'(late_cnt - lt0), 32'd1);
        check("late_data",  32'(cap),            32'd0);
        check("late_addr",  32'(last_addr),      32'h055);
        rsp_delay = 2;

        // write to 0x003 cut after 14 rises
        snap();
        spi_frame({9'h003, 1'b1, 16'h7777}, 14, 0, cap);
        check("abort_pulse",  32'(abort_cnt - ab0), 32'd1);
        check("abort_mvalid", 32'(mv_cnt - mv0),    32'd0);
        check("abort_addr",   32'(m_addr),  32'h003);
        check("abort_wdata",  32'(m_wdata), 32'hBEEF);

        snap();
        spi_frame({9'h004, 1'b1, 16'h1234}, 26, 0, cap);
        check("post_abort_mvalid", 32'(mv_cnt - mv0), 32'd1);
        check("post_abort_addr",   32'(last_addr),    32'h004);
        check("post_abort_wdata",  32'(last_wdata),   32'h1234);

        // 30 SCK pulses in one write frame
        snap();
        spi_frame({9'h1C0, 1'b1, 16'h5A5A}, 30, 0, cap);
        check("long_mvalid", 32'(mv_cnt - mv0),    32'd1);
        check("long_addr",   32'(m_addr),          32'h1C0);
        check("long_wdata",  32'(m_wdata),         32'h5A5A);
        check("long_abort",  32'(abort_cnt - ab0), 32'd0);

        // reset at rise 12 of a read, then a clean read of 0x010
        rsp_data = 16'h1111;
        snap();
        spi_frame({9'h010, 1'b0, 16'h0000}, 26, 12, cap);
        check("rst_abort", 32'(abort_cnt - ab0), 32'd0);
        check("rst_late",  32'(late_cnt - lt0),  32'd0);
        check_reset_outputs("after_reset");

        rsp_data = 16'h0F0F;
        snap();
        spi_frame({9'h010, 1'b0, 16'h0000}, 26, 0, cap);
        check("rst_rd_mvalid", 32'(mv_cnt - mv0), 32'd1);
        check("rst_rd_addr",   32'(m_addr),       32'h010);
        check("rst_rd_data",   32'(cap),          32'h0F0F);
        check("rst_rd_late",   32'(late_cnt - lt0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
